// File: rtl/i2c_target_pkg.sv
// Shared types and sizes for the I2C register target.
package i2c_target_pkg;

  localparam int NREGS = 16;
  localparam int PTR_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    SUBADDR,
    SUBACK,
    WDATA,
    WDACK,
    RDATA,
    RDACK,
    WAITSTOP
  } state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Host register-access bus of the I2C target register file.
interface i2c_target_regs_if;
  import i2c_target_pkg::*;

  logic [PTR_W-1:0] address;
  logic             chipselect;
  logic             write_n;
  logic [7:0]       writedata;
  logic [7:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/i2c_line_cond.sv
// Pad-line conditioner: 2-flop synchronizer, plus a 3-sample majority filter
// when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_line_cond (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], raw};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], sync_q[1]};
  end

  // majority of the live sample and two history samples: one-cycle pulses never win
  assign level = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign level = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16 x 8 register file to a host bus and an I2C master.
// Optional line glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// DEVADDR  | shifting in device address + R/W
// DEVACK   | driving ACK for device address
// SUBADDR  | shifting in register pointer byte
// SUBACK   | driving ACK for pointer byte
// WDATA    | shifting in write data byte
// WDACK    | driving ACK for write data
// RDATA    | shifting out register[ptr]
// RDACK    | sampling master ACK/NACK
// WAITSTOP | not addressed / done, ignore bits until START or STOP
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h5D
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  i2c_target_regs_if.slave host,
  output logic             i2c_wr,
  output logic [PTR_W-1:0] i2c_wr_idx,
  output logic             busy
);

  logic scl, sda, scl_q, sda_q;
  logic start_det, stop_det, scl_rise, scl_fall;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       shift_in;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [7:0]       wr_data;
  logic [7:0]       regs [NREGS];

  i2c_line_cond u_scl (.clk(clk), .reset_n(reset_n), .raw(scl_in), .level(scl));
  i2c_line_cond u_sda (.clk(clk), .reset_n(reset_n), .raw(sda_in), .level(sda));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign shift_in  = {shift[6:0], sda};
  assign ptr_nxt   = ptr + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ptr        <= '0;
      wr_data    <= '0;
      sda_oe     <= 1'b0;
      i2c_wr     <= 1'b0;
      i2c_wr_idx <= '0;
      busy       <= 1'b0;
    end else begin
      i2c_wr <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= DEVADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          DEVADDR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shift[7:1] == DEV_ADDR) begin
                state  <= DEVACK;
                sda_oe <= 1'b1;
              end else begin
                state <= WAITSTOP;
              end
            end
          end
          DEVACK: begin
            if (scl_fall) begin
              if (shift[0]) begin
                state  <= RDATA;
                shift  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                state  <= SUBADDR;
                sda_oe <= 1'b0;
              end
            end
          end
          SUBADDR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              ptr     <= shift[PTR_W-1:0];
              sda_oe  <= 1'b1;
              state   <= SUBACK;
            end
          end
          SUBACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                i2c_wr     <= 1'b1;
                i2c_wr_idx <= ptr;
                wr_data    <= shift_in;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b1;
              ptr     <= ptr_nxt;
              state   <= WDACK;
            end
          end
          WDACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= RDACK;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          RDACK: begin
            if (scl_rise) begin
              shift <= shift_in;
            end else if (scl_fall) begin
              if (!shift[0]) begin
                ptr    <= ptr_nxt;
                shift  <= regs[ptr_nxt];
                sda_oe <= ~regs[ptr_nxt][7];
                state  <= RDATA;
              end else begin
                state <= WAITSTOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // I2C commit lands one cycle after its pulse; a host write in that cycle overrides it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      host.readdata <= '0;
    end else begin
      if (i2c_wr) regs[i2c_wr_idx] <= wr_data;
      if (host.chipselect && !host.write_n) regs[host.address] <= host.writedata;
      host.readdata <= regs[host.address];
    end
  end

endmodule
